// File: rtl/mcs_fpro_bridge_ws.sv
// MicroBlaze MCS IO-bus to FPro-bus bridge with per-region wait states.
// Decodes the MCS IO window into N_REGION chip-select regions, issues a
// one-cycle fp_rd/fp_wr strobe, then completes either immediately (zero-wait
// region) or on the region's fp_ack, with a timeout. Misses and timeouts
// complete with an error and bump a sticky flag / saturating counter.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   io_addr_strobe/read/write     MCS access request and qualifiers
//   io_byte_enable, io_address    MCS byte enables and byte address
//   io_write_data                 MCS write data
//   io_read_data, io_ready        registered read data and completion pulse
//   fp_cs, fp_wr, fp_rd           one-hot chip select and one-cycle strobes
//   fp_addr, fp_wr_data, fp_be    word address, write data, byte enables
//   fp_rd_data, fp_ack            per-region read data and completion
//   err_clr, err, err_cnt         error clear, sticky flag, saturating count
module mcs_fpro_bridge_ws #(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int unsigned N_REGION = 2,
    parameter int unsigned ADDR_W   = 21,
    parameter logic [7:0]  ACK_MASK = 8'b0000_0010,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_addr_strobe,
    input  logic                    io_read_strobe,
    input  logic                    io_write_strobe,
    input  logic [3:0]              io_byte_enable,
    input  logic [31:0]             io_address,
    input  logic [31:0]             io_write_data,
    output logic [31:0]             io_read_data,
    output logic                    io_ready,
    output logic [N_REGION-1:0]     fp_cs,
    output logic                    fp_wr,
    output logic                    fp_rd,
    output logic [ADDR_W-1:0]       fp_addr,
    output logic [31:0]             fp_wr_data,
    output logic [3:0]              fp_be,
    input  logic [32*N_REGION-1:0]  fp_rd_data,
    input  logic [N_REGION-1:0]     fp_ack,
    input  logic                    err_clr,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    localparam int unsigned REG_W   = (N_REGION > 1) ? $clog2(N_REGION) : 1;
    localparam int unsigned REG_LSB = ADDR_W + 2;
    localparam int unsigned DEC_LSB = ADDR_W + 2 + REG_W;
    localparam int unsigned CNT_W   = 16;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

    state_t                 state_q, state_d;
    logic [REG_W-1:0]       region_q, region_d;
    logic                   is_rd_q, is_rd_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

    logic [31:0]            io_read_data_d;
    logic                   io_ready_d;
    logic [N_REGION-1:0]    fp_cs_d;
    logic                   fp_wr_d, fp_rd_d;
    logic [ADDR_W-1:0]      fp_addr_d;
    logic [31:0]            fp_wr_data_d;
    logic [3:0]             fp_be_d;
    logic                   err_d;
    logic [7:0]             err_cnt_d, err_cnt_base;
    logic                   err_evt;

    logic [REG_W-1:0]       io_region;
    logic                   io_hit, io_mapped, io_start;
    logic [31:0]            sel_rd_data;
    logic                   sel_ack, sel_acked;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^io_address[1:0];

    // Address decode of the incoming MCS access
    assign io_region = io_address[REG_LSB +: REG_W];
    assign io_hit    = (io_address[31:DEC_LSB] == BRG_BASE[31:DEC_LSB]);
    assign io_mapped = (32'(io_region) < N_REGION);
    assign io_start  = io_addr_strobe && (io_read_strobe || io_write_strobe);

    // Per-region mux for the latched region: read data, ack and ack mode
    always_comb begin
        sel_rd_data = '0;
        sel_ack     = 1'b0;
        sel_acked   = 1'b0;
        for (int unsigned r = 0; r < N_REGION; r++) begin
            if (region_q == REG_W'(r)) begin
                sel_rd_data = fp_rd_data[32*r +: 32];
                sel_ack     = fp_ack[r];
                sel_acked   = ACK_MASK[r];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        region_d       = region_q;
        is_rd_d        = is_rd_q;
        wait_cnt_d     = wait_cnt_q;
        io_read_data_d = io_read_data;
        io_ready_d     = 1'b0;
        fp_cs_d        = fp_cs;
        fp_wr_d        = 1'b0;
        fp_rd_d        = 1'b0;
        fp_addr_d      = fp_addr;
        fp_wr_data_d   = fp_wr_data;
        fp_be_d        = fp_be;
        err_evt        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io_start) begin
                    if (io_hit && io_mapped) begin
                        state_d      = S_REQ;
                        region_d     = io_region;
                        is_rd_d      = io_read_strobe;
                        fp_cs_d      = N_REGION'(1) << io_region;
                        fp_rd_d      = io_read_strobe;
                        fp_wr_d      = !io_read_strobe;
                        fp_addr_d    = io_address[REG_LSB-1:2];
                        fp_wr_data_d = io_write_data;
                        fp_be_d      = io_byte_enable;
                    end else begin
                        // Miss: complete immediately, no FPro activity
                        state_d        = S_ERR;
                        io_ready_d     = 1'b1;
                        io_read_data_d = '0;
                        err_evt        = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (!sel_acked || sel_ack) begin
                    state_d    = S_DONE;
                    io_ready_d = 1'b1;
                    fp_cs_d    = '0;
                    if (is_rd_q) begin
                        io_read_data_d = sel_rd_data;
                    end
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Ack takes priority over a timeout in the same cycle
                if (sel_ack) begin
                    state_d    = S_DONE;
                    io_ready_d = 1'b1;
                    fp_cs_d    = '0;
                    if (is_rd_q) begin
                        io_read_data_d = sel_rd_data;
                    end
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d        = S_ERR;
                    io_ready_d     = 1'b1;
                    fp_cs_d        = '0;
                    io_read_data_d = TO_DATA;
                    err_evt        = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Clear first, then count a coincident error event
        err_d        = err_clr ? 1'b0 : err;
        err_cnt_base = err_clr ? 8'd0 : err_cnt;
        err_cnt_d    = err_cnt_base;
        if (err_evt) begin
            err_d = 1'b1;
            if (err_cnt_base != 8'hFF) begin
                err_cnt_d = err_cnt_base + 8'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            region_q     <= '0;
            is_rd_q      <= 1'b0;
            wait_cnt_q   <= '0;
            io_read_data <= '0;
            io_ready     <= 1'b0;
            fp_cs        <= '0;
            fp_wr        <= 1'b0;
            fp_rd        <= 1'b0;
            fp_addr      <= '0;
            fp_wr_data   <= '0;
            fp_be        <= '0;
            err          <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            is_rd_q      <= is_rd_d;
            wait_cnt_q   <= wait_cnt_d;
            io_read_data <= io_read_data_d;
            io_ready     <= io_ready_d;
            fp_cs        <= fp_cs_d;
            fp_wr        <= fp_wr_d;
            fp_rd        <= fp_rd_d;
            fp_addr      <= fp_addr_d;
            fp_wr_data   <= fp_wr_data_d;
            fp_be        <= fp_be_d;
            err          <= err_d;
            err_cnt      <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_mcs_fpro_bridge_ws.sv
// Self-checking bench for mcs_fpro_bridge_ws (N_REGION=2, region 1 acked,
// TIMEOUT=3). Table of accesses plus hand sequences for error saturation,
// clear/increment collision and reset during a wait.
module tb_mcs_fpro_bridge_ws;

    localparam int NR = 2;
    localparam int AW = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]        io_byte_enable;
    logic [31:0]       io_address, io_write_data, io_read_data;
    logic              io_ready;
    logic [NR-1:0]     fp_cs;
    logic              fp_wr, fp_rd;
    logic [AW-1:0]     fp_addr;
    logic [31:0]       fp_wr_data;
    logic [3:0]        fp_be;
    logic [32*NR-1:0]  fp_rd_data;
    logic [NR-1:0]     fp_ack;
    logic              err_clr, err;
    logic [7:0]        err_cnt;

    mcs_fpro_bridge_ws #(
        .BRG_BASE (32'hc000_0000),
        .N_REGION (NR),
        .ADDR_W   (AW),
        .ACK_MASK (8'b0000_0010),
        .TIMEOUT  (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_wr_data      (fp_wr_data),
        .fp_be           (fp_be),
        .fp_rd_data      (fp_rd_data),
        .fp_ack          (fp_ack),
        .err_clr         (err_clr),
        .err             (err),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          ack_at;    // cycle offset from strobe cycle, -1 = never
        logic [1:0]  ack_bits;
        int          lat;       // io_ready cycle offset from strobe cycle
        logic [31:0] rdata;     // expected read data for reads / errors
        logic        is_err;
        logic        miss;
        logic [1:0]  cs;
        logic [20:0] faddr;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;
    logic [7:0]  m_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one access, push its expectation, and follow it to io_ready
    task automatic run_vec(input vec_t v, input logic clr);
        exp_t e, got;
        int   cyc, cs_first, cs_last, nrd, nwr, strb_cyc;
        bit   done, cs_changed, hold_changed;
        logic [NR-1:0] cs_val;
        logic [AW-1:0] a1;
        logic [31:0]   wd1;
        logic [3:0]    be1;

        if (v.rd || v.is_err) m_rdata = v.rdata;
        if (clr) begin m_err = 1'b0; m_cnt = 8'd0; end
        if (v.is_err) begin
            m_err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.lat = v.lat; e.rdata = m_rdata; e.err = m_err; e.cnt = m_cnt;
        sb.push_back(e);

        fp_rd_data      = {v.rd1, v.rd0};
        io_addr_strobe  = 1'b1;
        io_read_strobe  = v.rd;
        io_write_strobe = !v.rd;
        io_address      = v.addr;
        io_write_data   = v.wdata;
        io_byte_enable  = v.be;
        err_clr         = clr;
        fp_ack          = (v.ack_at == 0) ? v.ack_bits : '0;

        cyc = 0; done = 0; cs_first = -1; cs_last = -1; nrd = 0; nwr = 0;
        strb_cyc = -1; cs_changed = 0; hold_changed = 0; cs_val = '0;
        a1 = '0; wd1 = '0; be1 = '0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
            io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
            err_clr = 1'b0;
            if (cyc == 1) begin a1 = fp_addr; wd1 = fp_wr_data; be1 = fp_be; end
            if (fp_cs != '0) begin
                if (cs_first < 0) begin cs_first = cyc; cs_val = fp_cs; end
                else if (fp_cs != cs_val) cs_changed = 1;
                if (fp_addr != a1 || fp_wr_data != wd1 || fp_be != be1) hold_changed = 1;
                cs_last = cyc;
            end
            if (fp_rd) begin nrd++; strb_cyc = cyc; end
            if (fp_wr) begin nwr++; strb_cyc = cyc; end
            if (io_ready) begin
                done = 1;
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(got.lat));
                    chk("rd_data", io_read_data, got.rdata);
                    chk("err", 32'(err), 32'(got.err));
                    chk("err_cnt", 32'(err_cnt), 32'(got.cnt));
                end
            end
            fp_ack = (cyc == v.ack_at) ? v.ack_bits : '0;
        end
        fp_ack = '0;
        if (!done) chk("ready_timeout", 32'(cyc), 32'(v.lat));

        if (v.miss) begin
            chk("miss_no_cs", 32'(cs_first), 32'hFFFF_FFFF);
            chk("miss_no_strobe", 32'(nrd + nwr), 32'd0);
        end else begin
            chk("cs_first", 32'(cs_first), 32'd1);
            chk("cs_last", 32'(cs_last), 32'(v.lat - 1));
            chk("cs_value", 32'(cs_val), 32'(v.cs));
            chk("cs_stable", 32'(cs_changed), 32'd0);
            chk("rd_pulses", 32'(nrd), v.rd ? 32'd1 : 32'd0);
            chk("wr_pulses", 32'(nwr), v.rd ? 32'd0 : 32'd1);
            chk("strobe_cycle", 32'(strb_cyc), 32'd1);
            chk("fp_addr", 32'(a1), 32'(v.faddr));
            chk("fp_wr_data", wd1, v.wdata);
            chk("fp_be", 32'(be1), 32'(v.be));
            chk("fp_hold", 32'(hold_changed), 32'd0);
        end
        step();
        chk("ready_pulse", 32'(io_ready), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rdata"}, io_read_data, 32'd0);
        chk({name, "_ctl"}, 32'({io_ready, fp_cs, fp_wr, fp_rd, err}), 32'd0);
        chk({name, "_fpbus"}, 32'({fp_addr, fp_be}) | fp_wr_data, 32'd0);
        chk({name, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    vec_t vecs[12];
    vec_t miss_v;
    vec_t rd0_v;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr          rd    wdata          be       rd0            rd1           ack ackb   lat rdata         err miss cs     faddr
        vecs[0]  = '{32'hC000_0010, 1'b1, 32'h0,         4'b1111, 32'h1234_5678, 32'h0,         -1, 2'b00, 2, 32'h1234_5678, 0, 0, 2'b01, 21'h4};
        vecs[1]  = '{32'hC080_0008, 1'b0, 32'hA5A5_0001, 4'b0011, 32'h0,         32'h0,          4, 2'b10, 5, 32'h0,         0, 0, 2'b10, 21'h2};
        vecs[2]  = '{32'hC080_0000, 1'b1, 32'h0,         4'b1111, 32'h0,         32'h7777_7777, -1, 2'b00, 5, 32'hDEAD_BEEF, 1, 0, 2'b10, 21'h0};
        vecs[3]  = '{32'h4000_0000, 1'b1, 32'h0,         4'b1111, 32'h1111_1111, 32'h2222_2222, -1, 2'b00, 1, 32'h0,         1, 1, 2'b00, 21'h0};
        vecs[4]  = '{32'hC080_0004, 1'b1, 32'h0,         4'b1111, 32'h0,         32'hCAFE_0001,  1, 2'b10, 2, 32'hCAFE_0001, 0, 0, 2'b10, 21'h1};
        vecs[5]  = '{32'hC080_0010, 1'b1, 32'h0,         4'b1111, 32'h0,         32'h3333_3333,  0, 2'b10, 5, 32'hDEAD_BEEF, 1, 0, 2'b10, 21'h4};
        vecs[6]  = '{32'hC080_0020, 1'b1, 32'h0,         4'b0101, 32'h0,         32'h4444_4444,  2, 2'b01, 5, 32'hDEAD_BEEF, 1, 0, 2'b10, 21'h8};
        vecs[7]  = '{32'hC0FF_FFF0, 1'b1, 32'h0,         4'b1111, 32'h0,         32'h5555_AAAA,  3, 2'b10, 4, 32'h5555_AAAA, 0, 0, 2'b10, 21'h1F_FFFC};
        vecs[8]  = '{32'hC000_FFFC, 1'b0, 32'h0F0F_F0F0, 4'b1111, 32'h0,         32'h0,         -1, 2'b00, 2, 32'h0,         0, 0, 2'b01, 21'h3FFF};
        vecs[9]  = '{32'hC100_0000, 1'b0, 32'h9999_9999, 4'b1111, 32'h0,         32'h0,         -1, 2'b00, 1, 32'h0,         1, 1, 2'b00, 21'h0};
        vecs[10] = '{32'hC07F_FFFC, 1'b1, 32'h0,         4'b1111, 32'h0BAD_F00D, 32'h0,         -1, 2'b00, 2, 32'h0BAD_F00D, 0, 0, 2'b01, 21'h1F_FFFF};
        vecs[11] = '{32'hC080_0100, 1'b0, 32'h8000_0001, 4'b1000, 32'h0,         32'h0,          1, 2'b10, 2, 32'h0,         0, 0, 2'b10, 21'h40};
        miss_v = vecs[3];
        rd0_v  = vecs[0];

        reset = 1'b1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_byte_enable = '0; io_address = '0; io_write_data = '0;
        fp_rd_data = '0; fp_ack = '0; err_clr = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

        // Standalone clear
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 1'b0; m_cnt = 8'd0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);

        // Saturation, then clear coincident with one more miss
        for (int i = 0; i < 260; i++) run_vec(miss_v, 1'b0);
        chk("sat_cnt", 32'(err_cnt), 32'd255);
        run_vec(miss_v, 1'b1);
        chk("clr_inc_cnt", 32'(err_cnt), 32'd1);

        // Reset while waiting on an acked region
        fp_rd_data = '0;
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_write_strobe = 1'b0;
        io_address = 32'hC080_0000;
        step();
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
        step();
        chk("wait_cs", 32'(fp_cs), 32'(2'b10));
        chk("wait_no_strobe", 32'({fp_rd, fp_wr}), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("abort");
        begin
            int ready_seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (io_ready) ready_seen++;
            end
            chk("abort_no_ready", 32'(ready_seen), 32'd0);
        end
        m_rdata = '0; m_err = 1'b0; m_cnt = 8'd0;
        run_vec(rd0_v, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcs_fpro_bridge_ws.md
Name: mcs_fpro_bridge_ws

Overview:
- Parametrised successor of the MicroBlaze MCS IO-bus to FPro-bus bridge.
- Decodes the MCS IO window into N_REGION chip-select regions and drives the FPro bus with one-cycle strobes.
- Adds per-region wait-state support (slave ack with timeout) and error reporting for unmapped or timed-out accesses.
- Sits between the cpu instance and the mmio/video subsystems in the top level.

Parameters:
- BRG_BASE, 32'hc000_0000, bridge base address; bits below ADDR_W+2+REG_W must be zero.
- N_REGION, 2, number of FPro slave regions (1..8); REG_W = max(1, clog2(N_REGION)).
- ADDR_W, 21, FPro word-address width.
- ACK_MASK, 'b10, bit r=1: region r completes on fp_ack[r]; bit r=0: fixed zero-wait region.
- TIMEOUT, 255, maximum wait cycles for acked regions (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- io_addr_strobe  in  1  MCS access strobe
- io_read_strobe  in  1  MCS read qualifier
- io_write_strobe  in  1  MCS write qualifier
- io_byte_enable  in  4  MCS byte enables
- io_address  in  32  MCS byte address
- io_write_data  in  32  MCS write data
- io_read_data  out  32  registered read data to MCS
- io_ready  out  1  one-cycle completion pulse to MCS
- fp_cs  out  N_REGION  one-hot region chip select
- fp_wr  out  1  write strobe
- fp_rd  out  1  read strobe
- fp_addr  out  ADDR_W  word address = io_address[ADDR_W+1:2]
- fp_wr_data  out  32  write data
- fp_be  out  4  byte enables
- fp_rd_data  in  32*N_REGION  per-region read data, region r at [32r+31:32r]
- fp_ack  in  N_REGION  per-region completion, used only where ACK_MASK[r]=1
- err_clr  in  1  clears err and err_cnt
- err  out  1  sticky error flag
- err_cnt  out  8  saturating error count

Behaviour:
- Reset: all outputs 0, FSM to IDLE. A reset mid-transaction aborts the access with no io_ready pulse.
- Decode:
  - hit = io_address[31:ADDR_W+2+REG_W] equals the same bits of BRG_BASE.
  - region = io_address[ADDR_W+1+REG_W:ADDR_W+2].
  - A region index >= N_REGION is unmapped.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - On io_addr_strobe with read or write strobe (cycle T), latch address, data, be, type and region.
  - Mapped hit goes to REQ; a miss or unmapped region goes to ERR.
- REQ (T+1):
  - fp_cs[region]=1; fp_rd or fp_wr=1 for this single cycle.
  - Zero-wait region: sample the fp_rd_data slice (reads) and go to DONE.
  - Acked region: if fp_ack[region]=1 this cycle, sample and go to DONE; else go to WAIT with wait counter = 1.
- WAIT:
  - fp_cs held; fp_rd and fp_wr are 0.
  - fp_ack[region]=1: sample data, go to DONE.
  - Counter reaching TIMEOUT without ack: load io_read_data=32'hDEAD_BEEF, go to ERR.
  - Otherwise increment the counter.
- DONE: io_ready=1 for one cycle with io_read_data valid; fp_cs=0; return to IDLE.
- ERR:
  - io_ready=1 for one cycle; io_read_data = 0 (miss) or 32'hDEAD_BEEF (timeout).
  - Set err; err_cnt += 1, saturating at 255. Return to IDLE.
  - No fp strobes are ever issued for a miss.
- fp_addr, fp_wr_data and fp_be are held stable from REQ until leaving WAIT/DONE.
- Write accesses leave io_read_data at its previous value, except on error.
- Latency from strobe cycle T:
  - zero-wait region: io_ready at T+2
  - acked region with ack at T+1+k: io_ready at T+2+k
  - miss: io_ready at T+1
- Strobes arriving outside IDLE are ignored.
- Acks on non-selected regions, or while in IDLE, are ignored.
- err_clr coincident with an error event: clear is applied first, then the increment (err=1, err_cnt=1).

Test Plan:
- Read to 0xC000_0010 (region 0, zero-wait) with fp_rd_data[31:0]=0x1234_5678 -> at T+1: fp_cs=01, fp_rd=1, fp_addr=4; at T+2: io_ready=1, io_read_data=0x1234_5678.
- Write 0xA5A5_0001 with be=4'b0011 to 0xC080_0008 (region 1, acked), fp_ack at T+4 -> fp_wr pulses only at T+1; fp_cs[1] high T+1..T+4; io_ready at T+5; err=0.
- Region 1 read with fp_ack held 0, TIMEOUT=3 -> io_ready at T+5, io_read_data=0xDEAD_BEEF, err=1, err_cnt=1.
- Read to 0x4000_0000 (miss) -> io_ready at T+1, data 0, no fp_cs/fp_rd activity, err_cnt increments.
- 260 consecutive misses, then err_clr coincident with one more miss -> err_cnt saturates at 255, then reads 1.
- Reset asserted in WAIT -> no io_ready; all outputs 0 next cycle; a following zero-wait read completes at T+2.
